// File: rtl/rom_bit_sequencer.sv
// rom_bit_sequencer: start/stop controlled, range-programmable read sequencer
// for a 1-bit wide block ROM with a 1-cycle read latency. Bits are delivered
// downstream through a 2-entry FIFO. Reads are issued only when the FIFO has
// room for them (credit-based issue), so the FIFO can never overflow.
//
// Handshake: bit_valid/bit_ready follow strict valid/ready rules. bit_valid
// and bit_out depend only on registers. Once bit_valid is high it stays high
// and bit_out stays stable until a transfer (bit_valid & bit_ready) occurs at
// a rising clock edge.

module rom_bit_sequencer #(
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              stop,
  input  logic              loop_en,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] last_addr,
  output logic [ADDR_W-1:0] rom_addr,
  output logic              rom_en,
  input  logic              rom_dout,
  output logic              bit_out,
  output logic              bit_valid,
  input  logic              bit_ready,
  output logic              busy,
  output logic              done,
  output logic [1:0]        state_dbg
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] ptr;
  logic [ADDR_W-1:0] base_l;
  logic [ADDR_W-1:0] last_l;
  logic [ADDR_W-1:0] addr_hold;
  logic              loop_l;
  logic              inflight;
  logic [1:0]        fifo_count;
  logic              fifo_h0;
  logic              fifo_h1;
  logic              pop;
  logic              issue;
  logic              at_last;
  logic [2:0]        occ;

  // Occupancy after this cycle's pop: buffered bits plus the read in flight.
  assign pop     = bit_valid & bit_ready;
  assign occ     = {1'b0, fifo_count} + {2'b00, inflight} - {2'b00, pop};
  assign issue   = (state == RUN) && (occ < 3'd2);
  assign at_last = (ptr == last_l);

  assign rom_en    = issue;
  assign rom_addr  = issue ? ptr : addr_hold;
  assign bit_out   = fifo_h0;
  assign bit_valid = (fifo_count != 2'd0);
  assign busy      = (state != IDLE);
  assign state_dbg = state;

  // Sequencing FSM: range latch, issue pointer, end-of-range and stop handling.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      ptr    <= '0;
      base_l <= '0;
      last_l <= '0;
      loop_l <= 1'b0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            base_l <= base_addr;
            last_l <= last_addr;
            loop_l <= loop_en;
            ptr    <= base_addr;
            state  <= RUN;
          end
        end
        RUN: begin
          if (issue) begin
            // A loop wrap reloads the base directly, so no gap cycle appears.
            if (at_last && loop_l) begin
              ptr <= base_l;
            end else begin
              ptr <= ptr + ADDR_W'(1);
            end
          end
          if (stop || (issue && at_last && !loop_l)) begin
            state <= DRAIN;
          end
        end
        DRAIN: begin
          // Leave as soon as the last buffered bit is being consumed, so done
          // lands in the first cycle with nothing left to deliver.
          if (occ == 3'd0) begin
            state <= IDLE;
            done  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // In-flight flag and held ROM address for cycles without an issue.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inflight  <= 1'b0;
      addr_hold <= '0;
    end else begin
      inflight <= issue;
      if (issue) begin
        addr_hold <= ptr;
      end
    end
  end

  // Two-entry output FIFO; head is always fifo_h0. rom_dout is captured only
  // when a read is in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fifo_count <= 2'd0;
      fifo_h0    <= 1'b0;
      fifo_h1    <= 1'b0;
    end else begin
      case ({inflight, pop})
        2'b10: begin
          if (fifo_count == 2'd0) begin
            fifo_h0 <= rom_dout;
          end else begin
            fifo_h1 <= rom_dout;
          end
          fifo_count <= fifo_count + 2'd1;
        end
        2'b01: begin
          fifo_h0    <= fifo_h1;
          fifo_count <= fifo_count - 2'd1;
        end
        2'b11: begin
          if (fifo_count == 2'd1) begin
            fifo_h0 <= rom_dout;
          end else begin
            fifo_h0 <= fifo_h1;
            fifo_h1 <= rom_dout;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/rom_bit_sequencer.md
# rom_bit_sequencer

Sequencing controller for the 16-entry x 1-bit bit-pattern block ROM. It replaces free-running address counting with a start/stop-controlled, range-programmable, optionally looping read sequence. It delivers ROM bits to the downstream consumer over a valid/ready handshake at up to one bit per clock. The block owns the ROM address port, absorbs the ROM's 1-cycle read latency with a 2-entry output FIFO and credit-based issue, and sits between the ROM instance and the bit consumer.

## Interface
- ADDR_W, 4, ROM address width; ROM depth is 2^ADDR_W.

- clk  in  1  single clock; all logic on posedge
- rst  in  1  asynchronous, active-high reset
- start  in  1  one-cycle request to begin a sequence; honoured only in IDLE
- stop  in  1  request to end the sequence early; honoured only in RUN
- loop_en  in  1  repeat range indefinitely; sampled at accepted start
- base_addr  in  ADDR_W  first ROM address; sampled at accepted start
- last_addr  in  ADDR_W  final ROM address, inclusive; sampled at accepted start
- rom_addr  out  ADDR_W  to ROM addra
- rom_en  out  1  read issued this cycle; drives ena if the ROM has one
- rom_dout  in  1  ROM douta; valid one cycle after issue
- bit_out  out  1  FIFO head bit
- bit_valid  out  1  bit_out is valid
- bit_ready  in  1  consumer accepts; transfer = bit_valid & bit_ready
- busy  out  1  high in RUN and DRAIN
- done  out  1  one-cycle pulse at sequence completion

## Operation
- Reset values: rom_addr=0, rom_en=0, bit_out=0, bit_valid=0, busy=0, done=0. FIFO is empty, the in-flight flag is clear, and the state is IDLE.
- FSM states: IDLE, RUN, DRAIN.
- IDLE -> RUN on start. Latch base_addr, last_addr and loop_en, and load the issue pointer with base_addr. When start and stop are both high in IDLE, start wins and stop is ignored.
- RUN, read issue:
  - Issue a read when fifo_count + inflight - pop < 2, where pop = bit_valid & bit_ready.
  - On issue: rom_en=1, rom_addr=pointer, inflight<=1, pointer <= pointer+1 modulo 2^ADDR_W.
  - When no read is issued: rom_en=0, inflight<=0, and rom_addr holds its last value.
- RUN, end of range:
  - Issuing last_addr with loop_en=1 reloads the pointer with the latched base, with no gap cycle.
  - Issuing last_addr with loop_en=0 moves to DRAIN.
- RUN -> DRAIN on stop. Once stop is seen, no further reads are issued. The read issued in the same cycle as stop, if any, still completes and is delivered.
- DRAIN -> IDLE when inflight=0 and the FIFO is empty. done pulses in the first IDLE cycle; busy is low in that same cycle.
- Capture: when inflight=1, rom_dout is written into the FIFO at the end of that cycle. rom_dout is ignored otherwise, since the ROM reads every cycle.
- FIFO depth is 2. It never overflows by construction; a push and a pop in the same cycle are both honoured.
- Range arithmetic:
  - Sequence length = ((last - base) mod 2^ADDR_W) + 1.
  - base==last gives 1 bit per pass.
  - last<base wraps through address 2^ADDR_W-1 to 0.
- start while busy, and stop outside RUN, are ignored.
- rst mid-sequence returns the block immediately to reset values. Pending FIFO bits and the in-flight read are discarded, and no done pulse is generated.

## Timing
- Start accepted at cycle T:
  - T+1: RUN, first rom_en.
  - T+2: first bit captured.
  - T+3: bit_valid=1.
- Issue-to-bit_valid latency is 2 cycles.
- With bit_ready held high, throughput is 1 bit/cycle sustained, including across loop wraps.
- bit_ready low: at most 2 issues outstanding (FIFO plus in-flight). Issue resumes in the cycle bit_ready returns high.
- bit_out and bit_valid are registered with no combinational path from bit_ready. rom_en and rom_addr are combinational from state/counters/bit_ready, or registered equivalently with the same cycle numbering.
- Non-loop sequence of N bits with ready high: done pulses at T+N+3.

## Test plan
- ROM=0xA5C3 pattern, base=0, last=15, loop_en=0, ready=1: 16 bits appear on consecutive cycles from T+3 in ROM order; done at T+19; busy high T+1..T+18.
- base=14, last=1, loop_en=0: the bits from addresses 14,15,0,1 are delivered, exactly 4 bits, then done.
- base=5, last=5, loop_en=1, ready=1 for 10 cycles, then stop: the address-5 bit repeats every cycle. After stop, at most 2 further bits are delivered, then done. No bubbles occur before stop.
- base=0, last=7, ready toggling pseudo-randomly: the delivered sequence equals ROM[0..7] exactly, with no loss or duplication. rom_en is never high while the FIFO+in-flight count would exceed 2.
- start held high throughout a run: a single sequence occurs, then a new one starts in the cycle after done (IDLE with start high).
- rst asserted in RUN with 2 bits buffered: all outputs are 0 immediately, no done pulse, and a subsequent start runs normally from the new base.
